// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone traffic generator: CTI codes,
// controller state encoding and the error-counter width.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } wb_state_e;

endpackage

// File: rtl/wb_resp_timer.sv
// Per-beat response watchdog.
//   clk, rst_n       : clock, synchronous active-low reset
//   active_i         : a beat is outstanding (STB high)
//   stall_i          : slave stall, freezes the no-response counter
//   resp_i           : any of ACK/ERR/RTY seen this cycle
//   rty_i            : RTY is the winning response this cycle
//   beat_end_i       : current beat finished or was abandoned
//   timeout          : strobe, TIMEOUT-th silent non-stalled cycle
//   retry_exhausted  : strobe, RTY seen after MAX_RETRY reissues
module wb_resp_timer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic stall_i,
    input  logic resp_i,
    input  logic rty_i,
    input  logic beat_end_i,
    output logic timeout,
    output logic retry_exhausted
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RTY_W-1:0] rty_q, rty_d;

    assign timeout         = active_i && !resp_i && !stall_i && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign retry_exhausted = rty_i && (rty_q == RTY_W'(MAX_RETRY));

    // Silent-cycle counter restarts on any response or when no beat is out
    always_comb begin
        tmo_d = tmo_q;
        rty_d = rty_q;
        if (!active_i || resp_i) begin
            tmo_d = '0;
        end else if (!stall_i) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (beat_end_i) begin
            rty_d = '0;
        end else if (rty_i) begin
            rty_d = rty_q + RTY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
            rty_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            rty_q <= rty_d;
        end
    end

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone B4 traffic-generating master: writes NUM_WORDS pattern words from
// BASE_ADDR, reads them back and counts mismatches and bus errors.
//   WB_CLK_I, WB_RST_I      : clock, synchronous active-low reset
//   start_i, mode_i         : run trigger; 0 = classic single beats, 1 = bursts
//   busy_o, done_o, pass_o  : run status; done_o pulses one cycle at the end
//   err_count_o             : saturating error count of the last run
//   WB_*                    : Wishbone master port
module wb_traffic_gen
    import wb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_WORDS = 16,
    parameter int unsigned       BURST_LEN = 4,
    parameter int unsigned       MAX_RETRY = 3,
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(32'hA5A5_0000)
) (
    input  logic                 WB_CLK_I,
    input  logic                 WB_RST_I,
    input  logic                 start_i,
    input  logic                 mode_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [15:0]          err_count_o,
    output logic [ADDR_W-1:0]    WB_ADR_O,
    output logic [DATA_W-1:0]    WB_DAT_O,
    input  logic [DATA_W-1:0]    WB_DAT_I,
    output logic                 WB_WE_O,
    output logic                 WB_STB_O,
    output logic                 WB_CYC_O,
    output logic [2:0]           WB_CTI_O,
    input  logic                 WB_ACK_I,
    input  logic                 WB_ERR_I,
    input  logic                 WB_RTY_I,
    input  logic                 WB_STALL_I
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    wb_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, beat_idx, next_idx;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d, beat_bcnt;
    logic                   mode_q, mode_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]      dat_q, dat_d;
    logic [2:0]             cti_q, cti_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                   issue;

    logic req, rd, hit_ack, hit_err, hit_rty, timeout, retry_exhausted;
    logic beat_end, err_bump, last_word, last_in_burst;

    function automatic logic [ADDR_W-1:0] word_adr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + ADDR_W'(i) * ADDR_W'(BYTES);
    endfunction

    function automatic logic [DATA_W-1:0] word_dat(input logic [IDX_W-1:0] i);
        return SEED + DATA_W'(i);
    endfunction

    function automatic logic [2:0] beat_cti(input logic burst, input logic [IDX_W-1:0] i,
                                            input logic [BCNT_W-1:0] b);
        if (!burst) return CTI_CLASSIC;
        if (b == BCNT_W'(BURST_LEN - 1) || i == IDX_W'(NUM_WORDS - 1)) return CTI_EOB;
        return CTI_INCR;
    endfunction

    // Response decode, ERR > RTY > ACK, only while a beat is on the bus
    assign req     = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign rd      = (state_q == S_RD_REQ);
    assign hit_err = req && WB_ERR_I;
    assign hit_rty = req && !WB_ERR_I && WB_RTY_I;
    assign hit_ack = req && !WB_ERR_I && !WB_RTY_I && WB_ACK_I;

    assign next_idx      = idx_q + IDX_W'(1);
    assign last_word     = (idx_q == IDX_W'(NUM_WORDS - 1));
    assign last_in_burst = !mode_q || (bcnt_q == BCNT_W'(BURST_LEN - 1)) || last_word;
    assign beat_end      = hit_err || hit_ack || timeout || retry_exhausted;
    assign err_bump      = hit_err || timeout || retry_exhausted ||
                           (hit_ack && rd && (WB_DAT_I != word_dat(idx_q)));

    wb_resp_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_timer (
        .clk             (WB_CLK_I),
        .rst_n           (WB_RST_I),
        .active_i        (req),
        .stall_i         (WB_STALL_I),
        .resp_i          (WB_ACK_I || WB_ERR_I || WB_RTY_I),
        .rty_i           (hit_rty),
        .beat_end_i      (beat_end),
        .timeout         (timeout),
        .retry_exhausted (retry_exhausted)
    );

    // Controller next state and registered bus outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        mode_d    = mode_q;
        err_d     = err_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cti_d     = cti_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        beat_idx  = idx_q;
        beat_bcnt = bcnt_q;
        issue     = 1'b0;

        if (err_bump && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WR_REQ;
                    mode_d    = mode_i;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    beat_idx  = '0;
                    beat_bcnt = '0;
                    issue     = 1'b1;
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (hit_ack && !last_in_burst) begin
                    // Back-to-back burst beat: next word goes out with STB held
                    beat_idx  = next_idx;
                    beat_bcnt = bcnt_q + BCNT_W'(1);
                    issue     = 1'b1;
                end else if (beat_end) begin
                    idx_d  = next_idx;
                    bcnt_d = '0;
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    if (!rd) begin
                        state_d = S_WR_GAP;
                    end else if (last_word) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_RD_GAP;
                    end
                end else if (hit_rty) begin
                    // Same beat is reissued after the gap
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = rd ? S_RD_GAP : S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                if (idx_q == IDX_W'(NUM_WORDS)) begin
                    state_d   = S_RD_REQ;
                    we_d      = 1'b0;
                    beat_idx  = '0;
                    beat_bcnt = '0;
                end else begin
                    state_d = S_WR_REQ;
                end
                issue = 1'b1;
            end
            S_RD_GAP: begin
                state_d = S_RD_REQ;
                issue   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Launch a beat: latch its position and put the word on the bus
        if (issue) begin
            idx_d  = beat_idx;
            bcnt_d = beat_bcnt;
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            adr_d  = word_adr(beat_idx);
            dat_d  = word_dat(beat_idx);
            cti_d  = beat_cti(mode_d, beat_idx, beat_bcnt);
        end
    end

    always_ff @(posedge WB_CLK_I) begin
        if (!WB_RST_I) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bcnt_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cti_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cti_q   <= cti_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign WB_ADR_O    = adr_q;
    assign WB_DAT_O    = dat_q;
    assign WB_WE_O     = we_q;
    assign WB_STB_O    = stb_q;
    assign WB_CYC_O    = cyc_q;
    assign WB_CTI_O    = cti_q;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Bench for wb_traffic_gen: a behavioural Wishbone slave plus a transaction
// level model of the run (word index, burst position, retries, silent cycles,
// expected error count) checked against the DUT every cycle.
module tb_wb_traffic_gen;

    localparam int unsigned NW  = 10;
    localparam int unsigned BL  = 4;
    localparam int unsigned MR  = 3;
    localparam int unsigned TMO = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0;
    logic        busy, done, pass;
    logic [15:0] errc;
    logic [31:0] adr, dato, dati = 32'h0;
    logic        we, stb, cyc;
    logic [2:0]  cti;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0, stall = 1'b0;

    always #5 clk = ~clk;

    wb_traffic_gen #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .NUM_WORDS(NW),
        .BURST_LEN(BL), .MAX_RETRY(MR), .TIMEOUT(TMO), .SEED(SEED)
    ) dut (
        .WB_CLK_I(clk), .WB_RST_I(rst_n), .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(errc),
        .WB_ADR_O(adr), .WB_DAT_O(dato), .WB_DAT_I(dati), .WB_WE_O(we),
        .WB_STB_O(stb), .WB_CYC_O(cyc), .WB_CTI_O(cti), .WB_ACK_I(ack),
        .WB_ERR_I(err), .WB_RTY_I(rty), .WB_STALL_I(stall)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Slave behaviour knobs
    int k_rty_word = -1, k_rty_cnt = 0;
    int k_silent_word = -1;
    int k_stall_word = -1, k_stall_cnt = 0;
    int k_corrupt_word = -1;
    int k_rand = 0;
    logic [31:0] mem [NW];

    // Run model
    typedef enum {M_RST, M_IDLE, M_BUS, M_GAP, M_DONE} mst_e;
    mst_e m_st = M_RST, m_st_n = M_RST;
    bit   m_rd = 1'b0, m_mode = 1'b0, m_pass = 1'b0, idle_chk = 1'b0;
    int   m_idx = 0, m_pos = 0, m_retry = 0, m_silent = 0, m_err = 0;
    int   runs_done = 0;

    function automatic logic [2:0] exp_cti();
        if (!m_mode) return 3'b000;
        return (m_pos == BL - 1 || m_idx == NW - 1) ? 3'b111 : 3'b010;
    endfunction

    task automatic m_advance(input bit brk);
        m_retry  = 0;
        m_silent = 0;
        m_pos    = brk ? 0 : m_pos + 1;
        m_idx++;
        if (m_idx == NW) begin
            if (m_rd) begin
                m_st_n = M_DONE;
                m_pass = (m_err == 0);
            end else begin
                m_rd   = 1'b1;
                m_idx  = 0;
                m_pos  = 0;
                m_st_n = M_GAP;
            end
        end else begin
            m_st_n = brk ? M_GAP : M_BUS;
        end
    endtask

    task automatic m_fail();
        if (m_err < 16'hFFFF) m_err++;
        m_advance(1'b1);
    endtask

    // Slave + model, evaluated mid-cycle; responses land on the next posedge
    always @(negedge clk) begin : slave_model
        logic e_ack, e_err, e_rty, e_stall;
        logic [31:0] rdata;
        int widx;
        e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0; e_stall = 1'b0;
        rdata = 32'h0;
        m_st_n = m_st;
        case (m_st)
            M_RST: begin
                check("rst_ctl", {cyc, stb, we, busy, done, pass}, 0);
                check("rst_adr", adr, 0);
                check("rst_dat", dato, 0);
                check("rst_cti", cti, 0);
                check("rst_err", errc, 0);
                m_err = 0; m_pass = 1'b0;
                m_st_n = M_IDLE;
            end
            M_IDLE: begin
                if (idle_chk) begin
                    check("idle_ctl", {cyc, busy, done}, 0);
                    check("idle_pass", pass, m_pass);
                    check("idle_err", errc, m_err);
                    idle_chk = 1'b0;
                end
                if (start) begin
                    m_mode = mode; m_rd = 1'b0; m_idx = 0; m_pos = 0;
                    m_retry = 0; m_silent = 0; m_err = 0;
                    m_st_n = M_BUS;
                end
            end
            M_GAP: begin
                check("gap_ctl", {cyc, stb, busy, done}, 4'b0010);
                m_st_n = M_BUS;
            end
            M_DONE: begin
                check("done_ctl", {cyc, stb, busy, done}, 4'b0011);
                check("done_pass", pass, m_pass);
                check("done_err", errc, m_err);
                idle_chk = 1'b1;
                runs_done++;
                m_st_n = M_IDLE;
            end
            M_BUS: begin
                check("bus_ctl", {cyc, stb, busy, done}, 4'b1110);
                check("bus_we", we, !m_rd);
                check("bus_adr", adr, BASE + 32'(m_idx) * 4);
                check("bus_cti", cti, exp_cti());
                if (!m_rd) check("bus_wdat", dato, SEED + 32'(m_idx));
                widx = int'((adr - BASE) >> 2);
                if (widx < 0 || widx >= NW) widx = 0;
                if (!m_rd && widx == k_rty_word && k_rty_cnt > 0) begin
                    e_rty = 1'b1;
                    k_rty_cnt--;
                end else if (!m_rd && widx == k_silent_word) begin
                    e_ack = 1'b0;
                end else if (!m_rd && widx == k_stall_word && k_stall_cnt > 0) begin
                    e_stall = 1'b1;
                    k_stall_cnt--;
                end else if (k_rand > 0 && $urandom_range(99) < k_rand) begin
                    case ($urandom_range(3))
                        0: e_stall = 1'b1;
                        1: e_ack = 1'b0;
                        2: begin e_err = 1'b1; e_ack = 1'($urandom_range(1)); e_rty = 1'($urandom_range(1)); end
                        default: begin e_rty = 1'b1; e_ack = 1'($urandom_range(1)); end
                    endcase
                end else begin
                    e_ack = 1'b1;
                end
                if (m_rd) begin
                    rdata = mem[widx];
                    if (widx == k_corrupt_word || (k_rand > 0 && $urandom_range(9) == 0))
                        rdata[0] = ~rdata[0];
                end
                // Expected outcome of this cycle's response
                if (e_err) begin
                    m_fail();
                end else if (e_rty) begin
                    if (m_retry == MR) m_fail();
                    else begin m_retry++; m_silent = 0; m_st_n = M_GAP; end
                end else if (e_ack) begin
                    if (!m_rd) mem[widx] = dato;
                    if (m_rd && rdata != SEED + 32'(m_idx) && m_err < 16'hFFFF) m_err++;
                    m_advance(!m_mode || m_pos == BL - 1 || m_idx == NW - 1);
                end else begin
                    if (!e_stall) m_silent++;
                    if (m_silent == TMO) m_fail();
                end
            end
            default: m_st_n = M_RST;
        endcase
        if (!rst_n) m_st_n = M_RST;
        m_st  = m_st_n;
        ack   = e_ack;
        err   = e_err;
        rty   = e_rty;
        stall = e_stall;
        dati  = rdata;
    end

    task automatic do_run(input bit md, input bit glitch, input int exp_err);
        int r0;
        r0 = runs_done;
        @(posedge clk); #2 start = 1'b1; mode = md;
        @(posedge clk); #2 start = 1'b0;
        if (glitch) begin
            repeat (3) @(posedge clk);
            #2 start = 1'b1; mode = !md;
            @(posedge clk); #2 start = 1'b0;
        end
        for (int c = 0; c < 3000 && runs_done == r0; c++) @(posedge clk);
        check("run_end", runs_done != r0, 1);
        #2;
        if (exp_err >= 0) begin
            check("plan_err", errc, 16'(exp_err));
            check("plan_pass", pass, exp_err == 0);
        end
    endtask

    task automatic clear_knobs();
        k_rty_word = -1; k_rty_cnt = 0; k_silent_word = -1;
        k_stall_word = -1; k_stall_cnt = 0; k_corrupt_word = -1; k_rand = 0;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = ~(SEED + 32'(i));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        do_run(1'b0, 1'b0, 0);                                   // clean single beats
        do_run(1'b1, 1'b0, 0);                                   // clean bursts 4/4/2
        k_corrupt_word = 3;             do_run(1'b0, 1'b0, 1); clear_knobs();
        k_rty_word = 5; k_rty_cnt = 2;  do_run(1'b0, 1'b0, 0); clear_knobs();
        k_rty_word = 5; k_rty_cnt = 4;  do_run(1'b0, 1'b0, 1); clear_knobs();
        k_silent_word = 2;              do_run(1'b0, 1'b0, 1); clear_knobs();
        k_stall_word = 2; k_stall_cnt = 20; do_run(1'b0, 1'b0, 0); clear_knobs();
        k_corrupt_word = 9;             do_run(1'b1, 1'b1, 1); clear_knobs();

        // Reset in the middle of the read phase, then a clean run
        @(posedge clk); #2 start = 1'b1; mode = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int c = 0; c < 500 && !m_rd; c++) @(posedge clk);
        check("reach_read", m_rd, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_run(1'b1, 1'b0, 0);

        // Randomised response mix in both modes
        for (int r = 0; r < 12; r++) begin
            k_rand = 35;
            do_run(1'($urandom_range(1)), 1'($urandom_range(1)), -1);
        end
        clear_knobs();
        do_run(1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
